// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store responder for cpu_core driving a 32-bit async SRAM.
// Multi-cycle strobe, lane steering on stores, sign/zero extension on loads.
module data_mem_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk_50M,
  input  logic               reset_btn,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [4:0]         mem_ctrl_signal,
  output logic [31:0]        mem_rdata,
  output logic               mem_stall,
  output logic               addr_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [3:0]         sram_be_n,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [31:0]        sram_wdata,
  output logic               sram_data_oe,
  input  logic [31:0]        sram_rdata
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, DONE, ERR
  } state_t;

  localparam logic [2:0] WC_M1 = 3'(WAIT_CYCLES - 1);

  state_t      state, state_nx;
  logic [2:0]  cnt;
  logic        ld_q, uns_q;
  logic [1:0]  sz_q, off_q;
  logic [31:0] rdata_q;

  logic        req, bad, legal;
  logic [1:0]  sz;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] sh;
  logic [31:0] ext;
  logic        unused;

  assign unused = ^mem_addr[31:SRAM_AW+2];

  assign sz    = mem_ctrl_signal[1:0];
  assign req   = mem_ctrl_signal[4] | mem_ctrl_signal[3];
  assign bad   = (mem_ctrl_signal[4] & mem_ctrl_signal[3])
               | (sz == 2'b11)
               | ((sz == 2'b01) & mem_addr[0])
               | ((sz == 2'b10) & (|mem_addr[1:0]));
  assign legal = req & ~bad;

  always_comb begin
    be_c = 4'b1111;
    wd_c = mem_wdata;
    unique case (1'b1)
      sz == 2'b00: begin
        be_c = 4'b0001 << mem_addr[1:0];
        wd_c = {4{mem_wdata[7:0]}};
      end
      sz == 2'b01: begin
        be_c = mem_addr[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (!reset_btn) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (legal)    state_nx = ACCESS;
        else if (req) state_nx = ERR;
      end
      ACCESS: if (cnt == 3'd0) state_nx = DONE;
      DONE:   state_nx = IDLE;
      ERR:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (!reset_btn) begin
      cnt        <= '0;
      sram_addr  <= '0;
      sram_be_n  <= 4'hF;
      sram_wdata <= '0;
      ld_q       <= 1'b0;
      uns_q      <= 1'b0;
      sz_q       <= '0;
      off_q      <= '0;
      rdata_q    <= '0;
      addr_err   <= 1'b0;
    end else begin
      addr_err <= (state == IDLE) & req & bad;
      unique case (state)
        IDLE: begin
          if (legal) begin
            sram_addr  <= mem_addr[SRAM_AW+1:2];
            sram_be_n  <= ~be_c;
            sram_wdata <= wd_c;
            ld_q       <= mem_ctrl_signal[4];
            uns_q      <= mem_ctrl_signal[2];
            sz_q       <= sz;
            off_q      <= mem_addr[1:0];
            cnt        <= WC_M1;
          end
        end
        ACCESS: begin
          if (cnt == 3'd0) begin
            if (ld_q) rdata_q <= sram_rdata;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE:    sram_be_n <= 4'hF;
        default: ;
      endcase
    end
  end

  // Selected lane(s) shifted down to bit 0 before extension.
  assign sh = rdata_q >> {off_q, 3'b000};

  always_comb begin
    ext = rdata_q;
    unique case (1'b1)
      sz_q == 2'b00: ext = {{24{~uns_q & sh[7]}}, sh[7:0]};
      sz_q == 2'b01: ext = {{16{~uns_q & sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    sram_ce_n    = ~((state == ACCESS) | (state == DONE));
    sram_oe_n    = ~((state == ACCESS) & ld_q);
    sram_we_n    = ~((state == ACCESS) & ~ld_q);
    sram_data_oe = ~ld_q & ((state == ACCESS) | (state == DONE));
    mem_stall    = legal & (state != DONE) & reset_btn;
    mem_rdata    = (state == DONE) ? ext : 32'h0;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of data_mem_ctrl with WAIT_CYCLES=1 and 3.
// Each instance has its own SRAM model that commits a write on we_n release.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] addr[2], wdata[2], rdata_o[2], sram_wd[2], sram_rd[2];
  logic [4:0]  ctrl[2];
  logic        rst_n[2], stall[2], err[2];
  logic        ce_n[2], oe_n[2], we_n[2], doe[2];
  logic [3:0]  be_n[2];
  logic [19:0] saddr[2];

  data_mem_ctrl #(.WAIT_CYCLES(1), .SRAM_AW(20)) u_dut1 (
    .clk_50M(clk), .reset_btn(rst_n[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .mem_ctrl_signal(ctrl[0]), .mem_rdata(rdata_o[0]),
    .mem_stall(stall[0]), .addr_err(err[0]),
    .sram_addr(saddr[0]), .sram_be_n(be_n[0]),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]),
    .sram_we_n(we_n[0]), .sram_wdata(sram_wd[0]),
    .sram_data_oe(doe[0]), .sram_rdata(sram_rd[0])
  );

  data_mem_ctrl #(.WAIT_CYCLES(3), .SRAM_AW(20)) u_dut3 (
    .clk_50M(clk), .reset_btn(rst_n[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .mem_ctrl_signal(ctrl[1]), .mem_rdata(rdata_o[1]),
    .mem_stall(stall[1]), .addr_err(err[1]),
    .sram_addr(saddr[1]), .sram_be_n(be_n[1]),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]),
    .sram_we_n(we_n[1]), .sram_wdata(sram_wd[1]),
    .sram_data_oe(doe[1]), .sram_rdata(sram_rd[1])
  );

  logic [31:0] mem[2][64];
  logic        we_prev[2] = '{1'b1, 1'b1};
  int          ce_cnt[2] = '{0, 0};
  int          we_cnt[2] = '{0, 0};

  assign sram_rd[0] = mem[0][saddr[0][5:0]];
  assign sram_rd[1] = mem[1][saddr[1][5:0]];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!ce_n[i]) ce_cnt[i] <= ce_cnt[i] + 1;
      if (!we_n[i]) we_cnt[i] <= we_cnt[i] + 1;
      if (!ce_n[i] && we_n[i] && !we_prev[i]) begin
        for (int b = 0; b < 4; b++)
          if (!be_n[i][b])
            mem[i][saddr[i][5:0]][b*8 +: 8] <= sram_wd[i][b*8 +: 8];
      end
      we_prev[i] <= we_n[i];
    end
  end

  localparam logic [4:0] LW  = 5'b10010;
  localparam logic [4:0] LB  = 5'b10000;
  localparam logic [4:0] LBU = 5'b10100;
  localparam logic [4:0] LH  = 5'b10001;
  localparam logic [4:0] LHU = 5'b10101;
  localparam logic [4:0] SH  = 5'b01001;
  localparam logic [4:0] SW  = 5'b01010;
  localparam logic [4:0] BAD = 5'b10011;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic access(input int i, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] c,
                        output logic [31:0] rd, output int cyc,
                        output int stl, output logic [19:0] sa,
                        output logic [3:0] be, output logic [31:0] wd);
    bit done;
    done = 1'b0;
    addr[i] = a; wdata[i] = d; ctrl[i] = c;
    cyc = 0; stl = 0; rd = '0; sa = '0; be = '0; wd = '0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (stall[i]) stl++;
      else begin
        done = 1'b1;
        rd = rdata_o[i]; sa = saddr[i];
        be = be_n[i];    wd = sram_wd[i];
      end
      @(posedge clk); #1;
    end
    ctrl[i] = '0;
    chk("access_done", {31'b0, done}, 32'd1);
  endtask

  logic [31:0] rd, wd;
  logic [19:0] sa;
  logic [3:0]  be, pat;
  int          cyc, stl, c0, w0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wdata[i] = '0; ctrl[i] = '0; rst_n[i] = 1'b0;
    end
    ctrl[0] = LW;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_stall", {31'b0, stall[i]}, 32'd0);
      chk("rst_strobes", {29'b0, ce_n[i], oe_n[i], we_n[i]}, 32'd7);
      chk("rst_be_n", {28'b0, be_n[i]}, 32'hF);
      chk("rst_addr", {12'b0, saddr[i]}, 32'd0);
      chk("rst_wdata", sram_wd[i], 32'd0);
      chk("rst_doe_err", {30'b0, doe[i], err[i]}, 32'd0);
      chk("rst_rdata", rdata_o[i], 32'd0);
    end
    @(posedge clk); #1;
    ctrl[0] = '0;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    access(0, 32'h8000_0010, 32'hDEAD_BEEF, SW, rd, cyc, stl, sa, be, wd);
    chk("sw1_cyc", cyc, 3);
    chk("sw1_stall", stl, 2);
    access(0, 32'h8000_0010, 32'h0, LW, rd, cyc, stl, sa, be, wd);
    chk("lw1_cyc", cyc, 3);
    chk("lw1_stall", stl, 2);
    chk("lw1_addr", {12'b0, sa}, 32'h4);
    chk("lw1_be", {28'b0, be}, 32'h0);
    chk("lw1_data", rd, 32'hDEAD_BEEF);

    access(0, 32'h8000_0020, 32'h8011_2233, SW, rd, cyc, stl, sa, be, wd);
    access(0, 32'h8000_0023, 32'h0, LB, rd, cyc, stl, sa, be, wd);
    chk("lb_be", {28'b0, be}, 32'h7);
    chk("lb_data", rd, 32'hFFFF_FF80);
    access(0, 32'h8000_0023, 32'h0, LBU, rd, cyc, stl, sa, be, wd);
    chk("lbu_data", rd, 32'h0000_0080);
    access(0, 32'h8000_0022, 32'h0, LH, rd, cyc, stl, sa, be, wd);
    chk("lh_be", {28'b0, be}, 32'h3);
    chk("lh_data", rd, 32'hFFFF_8011);
    access(0, 32'h8000_0022, 32'h0, LHU, rd, cyc, stl, sa, be, wd);
    chk("lhu_data", rd, 32'h0000_8011);
    access(0, 32'h8000_0021, 32'h0, LB, rd, cyc, stl, sa, be, wd);
    chk("lb1_data", rd, 32'h0000_0022);

    access(0, 32'h8000_0030, 32'h1122_3344, SW, rd, cyc, stl, sa, be, wd);
    w0 = we_cnt[0];
    access(0, 32'h8000_0032, 32'h0000_ABCD, SH, rd, cyc, stl, sa, be, wd);
    chk("sh_be", {28'b0, be}, 32'h3);
    chk("sh_wdata", wd, 32'hABCD_ABCD);
    chk("sh_we_cycles", we_cnt[0] - w0, 1);
    access(0, 32'h8000_0030, 32'h0, LW, rd, cyc, stl, sa, be, wd);
    chk("sh_readback", rd, 32'hABCD_3344);

    c0 = ce_cnt[0];
    addr[0] = 32'h8000_0006; ctrl[0] = LW;
    @(negedge clk);
    chk("mis_stall0", {31'b0, stall[0]}, 32'd0);
    chk("mis_err0", {31'b0, err[0]}, 32'd0);
    chk("mis_rdata", rdata_o[0], 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mis_err1", {31'b0, err[0]}, 32'd1);
    chk("mis_stall1", {31'b0, stall[0]}, 32'd0);
    @(posedge clk); #1;
    ctrl[0] = '0;
    @(negedge clk);
    chk("mis_err2", {31'b0, err[0]}, 32'd0);
    chk("mis_no_ce", ce_cnt[0] - c0, 0);

    @(posedge clk); #1;
    addr[0] = 32'h8000_0000; ctrl[0] = BAD;
    pat = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat = {pat[2:0], err[0]};
      chk("bad_stall", {31'b0, stall[0]}, 32'd0);
      @(posedge clk); #1;
    end
    ctrl[0] = '0;
    chk("bad_err_pattern", {28'b0, pat}, 32'h5);
    chk("bad_no_ce", ce_cnt[0] - c0, 0);
    @(posedge clk); #1;

    w0 = we_cnt[1];
    access(1, 32'h8000_0040, 32'hCAFE_F00D, SW, rd, cyc, stl, sa, be, wd);
    chk("sw3_cyc", cyc, 5);
    chk("sw3_stall", stl, 4);
    chk("sw3_we_cycles", we_cnt[1] - w0, 3);
    access(1, 32'h8000_0040, 32'h0, LW, rd, cyc, stl, sa, be, wd);
    chk("lw3_cyc", cyc, 5);
    chk("lw3_stall", stl, 4);
    chk("lw3_data", rd, 32'hCAFE_F00D);

    access(1, 32'h8000_0050, 32'h5555_5555, SW, rd, cyc, stl, sa, be, wd);
    addr[1] = 32'h8000_0050; wdata[1] = 32'h1234_5678; ctrl[1] = SW;
    @(negedge clk);
    chk("abort_stall_idle", {31'b0, stall[1]}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_we_low", {31'b0, we_n[1]}, 32'd0);
    rst_n[1] = 1'b0;
    #1;
    chk("abort_stall_rst", {31'b0, stall[1]}, 32'd0);
    @(posedge clk); #1;
    chk("abort_strobes", {30'b0, we_n[1], ce_n[1]}, 32'd3);
    chk("abort_be_n", {28'b0, be_n[1]}, 32'hF);
    chk("abort_doe", {31'b0, doe[1]}, 32'd0);
    ctrl[1] = '0;
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("abort_mem", mem[1][20], 32'h5555_5555);
    chk("abort_idle", {30'b0, ce_n[1], stall[1]}, 32'd2);
    @(posedge clk); #1;
    access(1, 32'h8000_0050, 32'h0, LW, rd, cyc, stl, sa, be, wd);
    chk("abort_readback", rd, 32'h5555_5555);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
